// File: rtl/ysyx_23060332_mem_arbiter.sv
// Arbitrates one data-memory port between IFU and LSU, one transaction at a time.
// Ports: IFU/LSU valid/ready request + 1-cycle response pulse; memory req/resp; busy.
module ysyx_23060332_mem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 64,
    parameter int MASK_W  = 8,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ifu_req_valid,
    output logic              ifu_req_ready,
    input  logic [ADDR_W-1:0] ifu_addr,
    output logic              ifu_resp_valid,
    output logic [DATA_W-1:0] ifu_rdata,
    output logic              ifu_err,
    input  logic              lsu_req_valid,
    output logic              lsu_req_ready,
    input  logic              lsu_wen,
    input  logic [ADDR_W-1:0] lsu_addr,
    input  logic [DATA_W-1:0] lsu_wdata,
    input  logic [MASK_W-1:0] lsu_wmask,
    output logic              lsu_resp_valid,
    output logic [DATA_W-1:0] lsu_rdata,
    output logic              lsu_err,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic              mem_wen,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [MASK_W-1:0] mem_wmask,
    input  logic              mem_resp_valid,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT
    } state_e;

    state_e            state_q, state_d;
    // owner/last_owner encoding: 0 = IFU, 1 = LSU
    logic              owner_q, owner_d;
    logic              last_q, last_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              wen_q, wen_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [MASK_W-1:0] wmask_q, wmask_d;
    logic              ifu_rv_q, ifu_rv_d;
    logic              lsu_rv_q, lsu_rv_d;
    logic              ifu_err_q, ifu_err_d;
    logic              lsu_err_q, lsu_err_d;
    logic [DATA_W-1:0] ifu_rdata_q, ifu_rdata_d;
    logic [DATA_W-1:0] lsu_rdata_q, lsu_rdata_d;

    logic ifu_win;
    logic lsu_win;
    logic done;
    logic tmo;

    // On a tie the requester that did not own the last transaction wins.
    assign ifu_win = ifu_req_valid && (!lsu_req_valid || last_q);
    assign lsu_win = lsu_req_valid && (!ifu_req_valid || !last_q);

    // Gated with rst so every output reads 0 while reset is held.
    assign ifu_req_ready = rst && (state_q == S_IDLE) && ifu_win;
    assign lsu_req_ready = rst && (state_q == S_IDLE) && lsu_win;
    assign mem_req_valid = rst && (state_q == S_REQ);

    assign done = ((state_q == S_REQ) && mem_req_ready && mem_resp_valid)
               || ((state_q == S_WAIT) && mem_resp_valid);

    // Completion wins over timeout when both land in the same cycle.
    assign tmo = !done && (state_q != S_IDLE)
              && (cnt_q == CNT_W'(TIMEOUT - 1));

    assign mem_wen        = wen_q;
    assign mem_addr       = addr_q;
    assign mem_wdata      = wdata_q;
    assign mem_wmask      = wmask_q;
    assign busy           = (state_q != S_IDLE);
    assign ifu_resp_valid = ifu_rv_q;
    assign lsu_resp_valid = lsu_rv_q;
    assign ifu_err        = ifu_err_q;
    assign lsu_err        = lsu_err_q;
    assign ifu_rdata      = ifu_rdata_q;
    assign lsu_rdata      = lsu_rdata_q;

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        last_d      = last_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        wen_d       = wen_q;
        wdata_d     = wdata_q;
        wmask_d     = wmask_q;
        ifu_rv_d    = 1'b0;
        lsu_rv_d    = 1'b0;
        ifu_err_d   = 1'b0;
        lsu_err_d   = 1'b0;
        ifu_rdata_d = ifu_rdata_q;
        lsu_rdata_d = lsu_rdata_q;

        unique case (state_q)
            S_IDLE: begin
                if (ifu_req_ready) begin
                    owner_d = 1'b0;
                    last_d  = 1'b0;
                    addr_d  = ifu_addr;
                    wen_d   = 1'b0;
                    wdata_d = '0;
                    wmask_d = '0;
                    cnt_d   = '0;
                    state_d = S_REQ;
                end else if (lsu_req_ready) begin
                    owner_d = 1'b1;
                    last_d  = 1'b1;
                    addr_d  = lsu_addr;
                    wen_d   = lsu_wen;
                    wdata_d = lsu_wdata;
                    wmask_d = lsu_wen ? lsu_wmask : '0;
                    cnt_d   = '0;
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (mem_req_ready) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q + CNT_W'(1);
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (done || tmo) begin
            state_d = S_IDLE;
            if (owner_q) begin
                lsu_rv_d    = 1'b1;
                lsu_err_d   = tmo;
                lsu_rdata_d = (tmo || wen_q) ? '0 : mem_rdata;
            end else begin
                ifu_rv_d    = 1'b1;
                ifu_err_d   = tmo;
                ifu_rdata_d = tmo ? '0 : mem_rdata;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            owner_q     <= 1'b0;
            last_q      <= 1'b1;
            cnt_q       <= '0;
            addr_q      <= '0;
            wen_q       <= 1'b0;
            wdata_q     <= '0;
            wmask_q     <= '0;
            ifu_rv_q    <= 1'b0;
            lsu_rv_q    <= 1'b0;
            ifu_err_q   <= 1'b0;
            lsu_err_q   <= 1'b0;
            ifu_rdata_q <= '0;
            lsu_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            last_q      <= last_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            wen_q       <= wen_d;
            wdata_q     <= wdata_d;
            wmask_q     <= wmask_d;
            ifu_rv_q    <= ifu_rv_d;
            lsu_rv_q    <= lsu_rv_d;
            ifu_err_q   <= ifu_err_d;
            lsu_err_q   <= lsu_err_d;
            ifu_rdata_q <= ifu_rdata_d;
            lsu_rdata_q <= lsu_rdata_d;
        end
    end

endmodule

// File: tb/tb_ysyx_23060332_mem_arbiter.sv
// Directed bench for the IFU/LSU memory arbiter.
// Inputs change and outputs are sampled just after the falling edge.
module tb_ysyx_23060332_mem_arbiter;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        ifu_req_valid, ifu_req_ready;
    logic [31:0] ifu_addr;
    logic        ifu_resp_valid, ifu_err;
    logic [63:0] ifu_rdata;
    logic        lsu_req_valid, lsu_req_ready, lsu_wen;
    logic [31:0] lsu_addr;
    logic [63:0] lsu_wdata, lsu_rdata;
    logic [7:0]  lsu_wmask;
    logic        lsu_resp_valid, lsu_err;
    logic        mem_req_valid, mem_req_ready, mem_wen;
    logic [31:0] mem_addr;
    logic [63:0] mem_wdata, mem_rdata;
    logic [7:0]  mem_wmask;
    logic        mem_resp_valid, busy;

    int n_run  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    ysyx_23060332_mem_arbiter #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready),
        .ifu_addr(ifu_addr), .ifu_resp_valid(ifu_resp_valid),
        .ifu_rdata(ifu_rdata), .ifu_err(ifu_err),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready),
        .lsu_wen(lsu_wen), .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata),
        .lsu_wmask(lsu_wmask), .lsu_resp_valid(lsu_resp_valid),
        .lsu_rdata(lsu_rdata), .lsu_err(lsu_err),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wmask(mem_wmask), .mem_resp_valid(mem_resp_valid),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic clr_inputs();
        ifu_req_valid  = 1'b0;
        ifu_addr       = '0;
        lsu_req_valid  = 1'b0;
        lsu_wen        = 1'b0;
        lsu_addr       = '0;
        lsu_wdata      = '0;
        lsu_wmask      = '0;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        mem_rdata      = '0;
    endtask

    // Ends at a falling edge with reset released; caller drives cycle 0.
    task automatic do_reset();
        clr_inputs();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    logic [0:6] t_ir, t_lr, t_irs, t_lrs, t_mrq;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // ---- reset state: requests pending, outputs must stay 0 ----
        clr_inputs();
        rst = 1'b0;
        #2;
        ifu_req_valid = 1'b1;
        lsu_req_valid = 1'b1;
        #1;
        check("rst_ifu_rdy", ifu_req_ready, 0);
        check("rst_lsu_rdy", lsu_req_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_mreq", mem_req_valid, 0);
        check("rst_irsp", ifu_resp_valid, 0);
        check("rst_lrsp", lsu_resp_valid, 0);
        do_reset();

        // ---- T1: IFU read, combinational memory ----
        ifu_req_valid  = 1'b1;
        ifu_addr       = 32'h8000_0000;
        mem_req_ready  = 1'b1;
        mem_resp_valid = 1'b1;
        mem_rdata      = 64'hCAFE_F00D_1234_5678;
        #1;
        check("t1_ifu_rdy", ifu_req_ready, 1);
        check("t1_lsu_rdy", lsu_req_ready, 0);
        check("t1_mreq_c0", mem_req_valid, 0);
        @(negedge clk);
        ifu_req_valid = 1'b0;
        #1;
        check("t1_mreq_c1", mem_req_valid, 1);
        check("t1_maddr", mem_addr, 64'h8000_0000);
        check("t1_wmask", mem_wmask, 0);
        check("t1_wen", mem_wen, 0);
        check("t1_busy", busy, 1);
        check("t1_rsp_c1", ifu_resp_valid, 0);
        @(negedge clk);
        mem_resp_valid = 1'b0;
        #1;
        check("t1_rsp_c2", ifu_resp_valid, 1);
        check("t1_rdata", ifu_rdata, 64'hCAFE_F00D_1234_5678);
        check("t1_err", ifu_err, 0);
        check("t1_lrsp", lsu_resp_valid, 0);
        check("t1_busy2", busy, 0);
        @(negedge clk);
        #1;
        check("t1_rsp_c3", ifu_resp_valid, 0);
        check("t1_hold", ifu_rdata, 64'hCAFE_F00D_1234_5678);

        // ---- T2: both requesting, round robin IFU, LSU, IFU ----
        do_reset();
        t_ir  = 7'b1000100;
        t_lr  = 7'b0010001;
        t_irs = 7'b0010001;
        t_lrs = 7'b0000100;
        t_mrq = 7'b0101010;
        ifu_req_valid  = 1'b1;
        ifu_addr       = 32'h8000_0100;
        lsu_req_valid  = 1'b1;
        lsu_wen        = 1'b0;
        lsu_addr       = 32'h8000_0200;
        lsu_wmask      = 8'hFF;
        mem_req_ready  = 1'b1;
        mem_resp_valid = 1'b1;
        for (int c = 0; c < 7; c++) begin
            if (c > 0) @(negedge clk);
            mem_rdata = 64'h1000 + 64'(c);
            #1;
            check($sformatf("t2_irdy%0d", c), ifu_req_ready, t_ir[c]);
            check($sformatf("t2_lrdy%0d", c), lsu_req_ready, t_lr[c]);
            check($sformatf("t2_both%0d", c),
                  ifu_req_ready & lsu_req_ready, 0);
            check($sformatf("t2_irsp%0d", c), ifu_resp_valid, t_irs[c]);
            check($sformatf("t2_lrsp%0d", c), lsu_resp_valid, t_lrs[c]);
            check($sformatf("t2_mreq%0d", c), mem_req_valid, t_mrq[c]);
            if (t_irs[c])
                check($sformatf("t2_irdat%0d", c), ifu_rdata,
                      64'h1000 + 64'(c - 1));
            if (t_lrs[c])
                check($sformatf("t2_lrdat%0d", c), lsu_rdata,
                      64'h1000 + 64'(c - 1));
            if (c == 1 || c == 5)
                check($sformatf("t2_addr%0d", c), mem_addr, 64'h8000_0100);
            if (c == 3) begin
                check("t2_addr3", mem_addr, 64'h8000_0200);
                check("t2_rdmask", mem_wmask, 0);
            end
        end

        // ---- T3: LSU write with memory stalling the request ----
        do_reset();
        lsu_req_valid = 1'b1;
        lsu_wen       = 1'b1;
        lsu_addr      = 32'h8000_0010;
        lsu_wdata     = 64'h1122_3344_5566_7788;
        lsu_wmask     = 8'h0F;
        #1;
        check("t3_lrdy", lsu_req_ready, 1);
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            lsu_req_valid = 1'b0;
            lsu_addr      = 32'hDEAD_0000 + 32'(c);
            lsu_wdata     = '1;
            lsu_wmask     = 8'hF0;
            lsu_wen       = 1'b0;
            mem_req_ready = (c == 4);
            #1;
            check($sformatf("t3_mreq%0d", c), mem_req_valid, 1);
            check($sformatf("t3_addr%0d", c), mem_addr, 64'h8000_0010);
            check($sformatf("t3_wdat%0d", c), mem_wdata,
                  64'h1122_3344_5566_7788);
            check($sformatf("t3_mask%0d", c), mem_wmask, 64'h0F);
            check($sformatf("t3_wen%0d", c), mem_wen, 1);
        end
        @(negedge clk);
        mem_req_ready = 1'b0;
        #1;
        check("t3_wait_mreq", mem_req_valid, 0);
        check("t3_wait_busy", busy, 1);
        @(negedge clk);
        mem_resp_valid = 1'b1;
        mem_rdata      = 64'hDEAD_BEEF_DEAD_BEEF;
        #1;
        check("t3_lrsp_early", lsu_resp_valid, 0);
        @(negedge clk);
        mem_resp_valid = 1'b0;
        #1;
        check("t3_lrsp", lsu_resp_valid, 1);
        check("t3_lrdata", lsu_rdata, 0);
        check("t3_lerr", lsu_err, 0);
        check("t3_irsp", ifu_resp_valid, 0);

        // ---- T4: good read, then a read that times out ----
        do_reset();
        ifu_req_valid  = 1'b1;
        ifu_addr       = 32'h8000_0300;
        mem_req_ready  = 1'b1;
        mem_resp_valid = 1'b1;
        mem_rdata      = 64'hABCD;
        @(negedge clk);
        ifu_req_valid = 1'b0;
        @(negedge clk);
        ifu_req_valid  = 1'b1;
        ifu_addr       = 32'h8000_0340;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        #1;
        check("t4_rsp_ok", ifu_resp_valid, 1);
        check("t4_rdata_ok", ifu_rdata, 64'hABCD);
        check("t4_rdy2", ifu_req_ready, 1);
        for (int c = 0; c < TO; c++) begin
            @(negedge clk);
            ifu_req_valid = 1'b0;
            #1;
            check($sformatf("t4_busy%0d", c), busy, 1);
            check($sformatf("t4_nrsp%0d", c), ifu_resp_valid, 0);
            check($sformatf("t4_mreq%0d", c), mem_req_valid, 1);
        end
        @(negedge clk);
        mem_resp_valid = 1'b1;
        #1;
        check("t4_to_rsp", ifu_resp_valid, 1);
        check("t4_to_err", ifu_err, 1);
        check("t4_to_rdata", ifu_rdata, 0);
        check("t4_to_mreq", mem_req_valid, 0);
        check("t4_to_busy", busy, 0);
        check("t4_to_lrsp", lsu_resp_valid, 0);
        @(negedge clk);
        mem_resp_valid = 1'b0;
        #1;
        check("t4_late_irsp", ifu_resp_valid, 0);
        check("t4_late_lrsp", lsu_resp_valid, 0);
        check("t4_late_err", ifu_err, 0);
        check("t4_late_busy", busy, 0);

        // ---- T5: reset while waiting for the response ----
        do_reset();
        ifu_req_valid = 1'b1;
        ifu_addr      = 32'h8000_0400;
        mem_req_ready = 1'b1;
        @(negedge clk);
        ifu_req_valid = 1'b0;
        #1;
        check("t5_mreq", mem_req_valid, 1);
        @(negedge clk);
        mem_req_ready = 1'b0;
        #1;
        check("t5_wait", busy, 1);
        #1;
        ifu_req_valid = 1'b1;
        lsu_req_valid = 1'b1;
        rst = 1'b0;
        #1;
        check("t5_busy", busy, 0);
        check("t5_mreq0", mem_req_valid, 0);
        check("t5_irdy", ifu_req_ready, 0);
        check("t5_lrdy", lsu_req_ready, 0);
        check("t5_maddr", mem_addr, 0);
        check("t5_irsp", ifu_resp_valid, 0);
        mem_resp_valid = 1'b1;
        mem_rdata      = 64'h5757;
        @(negedge clk);
        ifu_req_valid  = 1'b0;
        lsu_req_valid  = 1'b0;
        mem_resp_valid = 1'b0;
        rst = 1'b1;
        #1;
        check("t5_nostale0", ifu_resp_valid, 0);
        @(negedge clk);
        mem_resp_valid = 1'b1;
        #1;
        check("t5_nostale1", ifu_resp_valid, 0);
        @(negedge clk);
        mem_resp_valid = 1'b0;
        #1;
        check("t5_nostale2", ifu_resp_valid, 0);
        check("t5_nostale_l", lsu_resp_valid, 0);
        ifu_req_valid  = 1'b1;
        ifu_addr       = 32'h8000_0500;
        mem_req_ready  = 1'b1;
        mem_resp_valid = 1'b1;
        mem_rdata      = 64'h5555_AAAA;
        #1;
        check("t5_rdy", ifu_req_ready, 1);
        @(negedge clk);
        ifu_req_valid = 1'b0;
        #1;
        check("t5_addr", mem_addr, 64'h8000_0500);
        @(negedge clk);
        mem_resp_valid = 1'b0;
        #1;
        check("t5_rsp", ifu_resp_valid, 1);
        check("t5_rdata", ifu_rdata, 64'h5555_AAAA);
        check("t5_err", ifu_err, 0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
